// File: rtl/bster_ram_rd_arbiter.sv
// bster_ram_rd_arbiter: round-robin sharing of the bster RAM AXI4 read channels between tree engines
//   aclk/areset        clock, asynchronous active-high reset
//   req_valid/ready    per-requester single-beat read request, req_addr packed per requester
//   rsp_valid/ready    per-requester response handshake, rsp_data/rsp_err shared
//   ram_axi_ar*        AXI4 read address channel (single beat, INCR, full-width)
//   ram_axi_r*         AXI4 read data channel, routed by rid
//   unmapped_rid       pulse one cycle after a response with an unknown rid is dropped
//   busy               address slot occupied or reads still in flight
module bster_ram_rd_arbiter #(
   parameter int NB_REQ          = 2,
   parameter int RAM_ADDR_WIDTH  = 16,
   parameter int RAM_DATA_WIDTH  = 32,
   parameter int RAM_ID_WIDTH    = 8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                             aclk,
   input  logic                             areset,
   input  logic [NB_REQ-1:0]                req_valid,
   output logic [NB_REQ-1:0]                req_ready,
   input  logic [NB_REQ*RAM_ADDR_WIDTH-1:0] req_addr,
   output logic [NB_REQ-1:0]                rsp_valid,
   input  logic [NB_REQ-1:0]                rsp_ready,
   output logic [RAM_DATA_WIDTH-1:0]        rsp_data,
   output logic                             rsp_err,
   output logic [RAM_ID_WIDTH-1:0]          ram_axi_arid,
   output logic [RAM_ADDR_WIDTH-1:0]        ram_axi_araddr,
   output logic [7:0]                       ram_axi_arlen,
   output logic [2:0]                       ram_axi_arsize,
   output logic [1:0]                       ram_axi_arburst,
   output logic                             ram_axi_arlock,
   output logic [3:0]                       ram_axi_arcache,
   output logic [2:0]                       ram_axi_arprot,
   output logic                             ram_axi_arvalid,
   input  logic                             ram_axi_arready,
   input  logic [RAM_ID_WIDTH-1:0]          ram_axi_rid,
   input  logic [RAM_DATA_WIDTH-1:0]        ram_axi_rdata,
   input  logic [1:0]                       ram_axi_rresp,
   input  logic                             ram_axi_rlast,
   input  logic                             ram_axi_rvalid,
   output logic                             ram_axi_rready,
   output logic                             unmapped_rid,
   output logic                             busy
);
   localparam int IDXW = $clog2(NB_REQ);

   logic                      arvalid_q, arvalid_d;
   logic [RAM_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [RAM_ID_WIDTH-1:0]   arid_q, arid_d;
   logic [IDXW-1:0]           rr_ptr_q, rr_ptr_d;
   logic [3:0]                out_cnt_q, out_cnt_d;
   logic                      unmapped_q, unmapped_d;

   logic [4:0]      pending;
   logic            found, load, ar_hs, r_last_hs, mapped;
   logic [IDXW-1:0] win, idx, rid_idx;

   // first requesting index at or after rr_ptr, wrapping
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int j = 0; j < NB_REQ; j++) begin
         idx = IDXW'((int'(rr_ptr_q) + j) % NB_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // pending counts the read parked in the slot as well as those in flight
   assign pending   = {1'b0, out_cnt_q} + {4'd0, arvalid_q};
   assign load      = (!arvalid_q || ram_axi_arready) && (pending < 5'(MAX_OUTSTANDING)) && found;
   assign ar_hs     = arvalid_q && ram_axi_arready;
   assign r_last_hs = ram_axi_rvalid && ram_axi_rready && ram_axi_rlast;
   assign mapped    = int'(ram_axi_rid) < NB_REQ;
   assign rid_idx   = ram_axi_rid[IDXW-1:0];

   assign req_ready = load ? (NB_REQ'(1) << win) : '0;

   always_comb begin
      arvalid_d  = load ? 1'b1 : (ar_hs ? 1'b0 : arvalid_q);
      araddr_d   = load ? req_addr[win*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH] : araddr_q;
      arid_d     = load ? RAM_ID_WIDTH'(win) : arid_q;
      rr_ptr_d   = load ? ((win == IDXW'(NB_REQ-1)) ? '0 : win + IDXW'(1)) : rr_ptr_q;
      // simultaneous issue and retire cancel; retire saturates at zero after a reset
      out_cnt_d  = (ar_hs && !r_last_hs) ? out_cnt_q + 4'd1 :
                   (!ar_hs && r_last_hs && out_cnt_q != 4'd0) ? out_cnt_q - 4'd1 : out_cnt_q;
      unmapped_d = ram_axi_rvalid && ram_axi_rready && !mapped;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         arvalid_q  <= 1'b0;
         araddr_q   <= '0;
         arid_q     <= '0;
         rr_ptr_q   <= '0;
         out_cnt_q  <= '0;
         unmapped_q <= 1'b0;
      end else begin
         arvalid_q  <= arvalid_d;
         araddr_q   <= araddr_d;
         arid_q     <= arid_d;
         rr_ptr_q   <= rr_ptr_d;
         out_cnt_q  <= out_cnt_d;
         unmapped_q <= unmapped_d;
      end
   end

   assign ram_axi_arvalid = arvalid_q;
   assign ram_axi_araddr  = araddr_q;
   assign ram_axi_arid    = arid_q;
   assign ram_axi_arlen   = 8'd0;
   assign ram_axi_arsize  = 3'($clog2(RAM_DATA_WIDTH/8));
   assign ram_axi_arburst = 2'b01;
   assign ram_axi_arlock  = 1'b0;
   assign ram_axi_arcache = 4'd0;
   assign ram_axi_arprot  = 3'd0;

   // unknown ids are drained so the RAM never stalls on them
   assign ram_axi_rready = mapped ? rsp_ready[rid_idx] : 1'b1;
   assign rsp_valid      = (ram_axi_rvalid && mapped) ? (NB_REQ'(1) << rid_idx) : '0;
   assign rsp_data       = ram_axi_rdata;
   assign rsp_err        = ram_axi_rresp != 2'b00;
   assign unmapped_rid   = unmapped_q;
   assign busy           = arvalid_q || (out_cnt_q != 4'd0);
endmodule

// File: tb/tb_bster_ram_rd_arbiter.sv
// tb_bster_ram_rd_arbiter: directed self-checking bench for bster_ram_rd_arbiter
module tb_bster_ram_rd_arbiter;
   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
   logic [31:0] req_addr = '0, rsp_data, rdata = '0;
   logic        rsp_err, arvalid, arready = 1'b0, arlock, rlast = 1'b0, rvalid = 1'b0, rready, unmapped, busy;
   logic [7:0]  arid, arlen, rid = '0;
   logic [15:0] araddr;
   logic [2:0]  arsize, arprot;
   logic [1:0]  arburst, rresp = '0;
   logic [3:0]  arcache;
   int n_assert = 0, n_fail = 0;

   bster_ram_rd_arbiter dut (
      .aclk(aclk), .areset(areset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .ram_axi_arid(arid), .ram_axi_araddr(araddr), .ram_axi_arlen(arlen), .ram_axi_arsize(arsize),
      .ram_axi_arburst(arburst), .ram_axi_arlock(arlock), .ram_axi_arcache(arcache), .ram_axi_arprot(arprot),
      .ram_axi_arvalid(arvalid), .ram_axi_arready(arready),
      .ram_axi_rid(rid), .ram_axi_rdata(rdata), .ram_axi_rresp(rresp), .ram_axi_rlast(rlast),
      .ram_axi_rvalid(rvalid), .ram_axi_rready(rready),
      .unmapped_rid(unmapped), .busy(busy)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic drain(input int n);
      rvalid = 1'b1; rid = 8'd0; rlast = 1'b1; rsp_ready = 2'b01; rresp = 2'b00;
      repeat (n) tick();
      rvalid = 1'b0; rsp_ready = 2'b00;
   endtask

   initial begin
      logic [7:0] exp_id;
      // reset state
      repeat (2) tick();
      chk("rst_arvalid", arvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_arid", arid, 0);
      chk("rst_unmapped", unmapped, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_arsize", arsize, 2);
      chk("rst_arburst", arburst, 1);
      chk("rst_arlen", arlen, 0);
      chk("rst_fixed", {arlock, arcache, arprot}, 0);
      areset = 1'b0;
      tick();

      // single read
      req_valid = 2'b01; req_addr = 32'h0000_0010; arready = 1'b1;
      #1 chk("single_req_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      chk("single_arvalid", arvalid, 1);
      chk("single_araddr", araddr, 16'h0010);
      chk("single_arid", arid, 0);
      tick();
      chk("single_ar_done", arvalid, 0);
      chk("single_busy", busy, 1);
      rid = 8'd0; rdata = 32'hDEAD_BEEF; rvalid = 1'b1; rlast = 1'b1; rsp_ready = 2'b01;
      #1;
      chk("single_rsp_valid", rsp_valid, 2'b01);
      chk("single_rsp_data", rsp_data, 32'hDEAD_BEEF);
      chk("single_rsp_err", rsp_err, 0);
      chk("single_rready", rready, 1);
      tick();
      rvalid = 1'b0;
      chk("single_idle", busy, 0);

      // fairness: pointer sits at 1 after the single read, so grants alternate 1,0,1,...
      req_valid = 2'b11; req_addr = 32'h2222_1111;
      rvalid = 1'b1; rid = 8'd0; rlast = 1'b1; rsp_ready = 2'b11;
      exp_id = 8'd1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("fair_arid_%0d", k), arid, exp_id);
         chk($sformatf("fair_araddr_%0d", k), araddr, exp_id[0] ? 16'h2222 : 16'h1111);
         exp_id = exp_id ^ 8'd1;
      end
      req_valid = 2'b00; rvalid = 1'b0; rsp_ready = 2'b00;
      tick();
      drain(1);
      chk("fair_idle", busy, 0);

      // outstanding cap
      req_valid = 2'b01; req_addr = 32'h0000_0040;
      repeat (5) tick();
      chk("cap_req_ready", req_ready, 2'b00);
      chk("cap_busy", busy, 1);
      chk("cap_arvalid", arvalid, 0);
      tick();
      chk("cap_still_blocked", req_ready, 2'b00);
      rvalid = 1'b1; rid = 8'd0; rlast = 1'b1; rsp_ready = 2'b01;
      #1 chk("cap_blocked_during_r", req_ready, 2'b00);
      tick();
      rvalid = 1'b0;
      #1 chk("cap_reopen", req_ready, 2'b01);
      tick();
      chk("cap_one_more", arvalid, 1);
      chk("cap_full_again", req_ready, 2'b00);
      req_valid = 2'b00;
      tick();
      drain(4);
      chk("cap_idle", busy, 0);

      // AR backpressure: pointer at 1
      arready = 1'b0; req_valid = 2'b11; req_addr = 32'h2222_1111;
      #1 chk("bp_first_grant", req_ready, 2'b10);
      tick();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_ready_%0d", k), req_ready, 2'b00);
         chk($sformatf("bp_araddr_%0d", k), araddr, 16'h2222);
         chk($sformatf("bp_arid_%0d", k), arid, 1);
         tick();
      end
      arready = 1'b1;
      #1 chk("bp_reload_grant", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      chk("bp_reload_valid", arvalid, 1);
      chk("bp_reload_addr", araddr, 16'h1111);
      chk("bp_reload_id", arid, 0);
      tick();

      // error response then unmapped id, two reads in flight
      rvalid = 1'b1; rid = 8'd1; rresp = 2'b10; rlast = 1'b1; rsp_ready = 2'b10;
      #1;
      chk("err_rsp_valid", rsp_valid, 2'b10);
      chk("err_rsp_err", rsp_err, 1);
      chk("err_rready", rready, 1);
      tick();
      rid = 8'd5; rresp = 2'b00; rsp_ready = 2'b00;
      #1;
      chk("unm_rready", rready, 1);
      chk("unm_rsp_valid", rsp_valid, 2'b00);
      chk("unm_not_yet", unmapped, 0);
      tick();
      rvalid = 1'b0;
      chk("unm_pulse", unmapped, 1);
      chk("unm_count_dec", busy, 0);
      tick();
      chk("unm_pulse_end", unmapped, 0);

      // reset mid-traffic: pointer at 1, requester 1 alone builds 3 in flight plus a parked slot
      req_valid = 2'b10;
      repeat (4) tick();
      chk("mid_busy", busy, 1);
      chk("mid_arvalid", arvalid, 1);
      areset = 1'b1;
      #1;
      chk("mid_rst_arvalid", arvalid, 0);
      chk("mid_rst_busy", busy, 0);
      req_valid = 2'b11;
      tick();
      areset = 1'b0;
      #1 chk("post_rst_grant", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      chk("post_rst_arid", arid, 0);
      tick();
      drain(1);
      // a stray late response must not wrap the counter below zero
      drain(1);
      chk("post_rst_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/bster_ram_rd_arbiter.md
# bster_ram_rd_arbiter

Round-robin arbiter sharing the bster RAM AXI4 read address/data channels between `NB_REQ` internal tree engines (search, insert, delete walkers). Each requester issues single-beat node reads through a simple valid/ready request port and receives the node word on a dedicated response port. The block sits between the engines and the `ram_axi_ar*`/`ram_axi_r*` ports of the bster top level. It tracks in-flight reads and routes responses by AXI ID.

## Interface

- `NB_REQ`, 2: number of requesters, 2..8.
- `RAM_ADDR_WIDTH`, 16: RAM address width in bits.
- `RAM_DATA_WIDTH`, 32: RAM data width in bits, power of two, at least 8.
- `RAM_ID_WIDTH`, 8: AXI ID width, at least clog2(NB_REQ).
- `MAX_OUTSTANDING`, 4: maximum reads issued and not yet answered, 1..15.

Ports:

- `aclk`  in  1  clock.
- `areset`  in  1  asynchronous reset, active-high.
- `req_valid`  in  NB_REQ  per-requester read request.
- `req_ready`  out  NB_REQ  per-requester request accept.
- `req_addr`  in  NB_REQ*RAM_ADDR_WIDTH  packed addresses; requester i uses slice i.
- `rsp_valid`  out  NB_REQ  per-requester response valid.
- `rsp_ready`  in  NB_REQ  per-requester response accept.
- `rsp_data`  out  RAM_DATA_WIDTH  response data, shared by all requesters.
- `rsp_err`  out  1  rresp != OKAY; qualified by any `rsp_valid`.
- `ram_axi_arid`, `ram_axi_araddr`, `ram_axi_arlen`, `ram_axi_arsize`, `ram_axi_arburst`, `ram_axi_arlock`, `ram_axi_arcache`, `ram_axi_arprot`, `ram_axi_arvalid`  out  AXI4 widths  read address channel.
- `ram_axi_arready`  in  1  read address channel ready.
- `ram_axi_rid`, `ram_axi_rdata`, `ram_axi_rresp`, `ram_axi_rlast`, `ram_axi_rvalid`  in  AXI4 widths  read data channel.
- `ram_axi_rready`  out  1  read data channel ready.
- `unmapped_rid`  out  1  one-cycle pulse when a response with rid >= NB_REQ is dropped.
- `busy`  out  1  high when `arvalid` is high or the outstanding count is nonzero.

## Operation

- **AR slot.** One output register holds `arvalid`, `araddr` and `arid`. Once `arvalid` is asserted, these values stay stable until `arvalid && arready`.
- **Pending count.** pending = outstanding + arvalid.
- **Load condition.** The slot loads when (!arvalid || arready) && pending < MAX_OUTSTANDING && |req_valid.
- **Arbitration.**
  - Search req_valid starting at `rr_ptr`, ascending, wrapping modulo NB_REQ. The first set bit, i, wins.
  - `req_ready[i]` = 1 combinationally in the load cycle. All other `req_ready` bits are 0.
  - `rr_ptr` becomes (i+1) mod NB_REQ.
- **AR fields.**
  - `arid` = i, zero-extended.
  - `araddr` = slice i of req_addr.
  - Fixed fields: `arlen`=0, `arsize`=log2(RAM_DATA_WIDTH/8), `arburst`=2'b01, `arlock`=0, `arcache`=0, `arprot`=0.
- **Outstanding counter.**
  - +1 on AR handshake.
  - −1 on `rvalid && rready && rlast`.
  - Both in the same cycle: no change.
  - The counter never decrements below 0.
- **R routing (combinational).**
  - k = rid. For k < NB_REQ: `rsp_valid[k]` = rvalid and `rready` = rsp_ready[k].
  - For k >= NB_REQ: `rready` = 1, all `rsp_valid` bits = 0, and `unmapped_rid` pulses on that handshake. The counter still decrements.
  - `rsp_data` = rdata.
  - `rsp_err` = (rresp != 2'b00).
- **Ordering.** Responses may interleave across IDs. Per requester, order follows the RAM's per-ID ordering.

## Timing

- Reset values: `arvalid`=0, `araddr`=0, `arid`=0, `rr_ptr`=0, outstanding=0, `unmapped_rid`=0, `busy`=0.
  - All other outputs are combinational. With no inputs active they are 0, except the fixed AR fields.
  - Reset takes effect immediately.
- Request-to-AR latency: a request accepted in cycle N drives `arvalid` in cycle N+1. With `arready` held high, one request is accepted per cycle.
- Response path: zero latency, no registers between `ram_axi_r*` and `rsp_*`.
- Reset mid-operation: the slot and counter clear. The RAM is reset on the same `areset`. Responses arriving after reset are routed normally, and the counter saturates at 0.
- `unmapped_rid` is registered: it is high in the cycle after the dropping handshake.

## Test plan

- **Single read.** req_valid=01, req_addr[0]=0x0010, arready=1 -> next cycle arvalid=1, araddr=0x0010, arid=0, arlen=0, arsize=2. Then rid=0, rdata=0xDEADBEEF, rvalid=1 -> same-cycle rsp_valid=01, rsp_data=0xDEADBEEF, rsp_err=0.
- **Fairness.** req_valid=11 held, arready=1, responses returned immediately -> arid sequence 0,1,0,1,0,1.
- **Outstanding cap.** MAX_OUTSTANDING=4, rvalid=0 -> exactly 4 AR handshakes, then req_ready=00 and busy=1. One R handshake -> one more AR accepted the next cycle.
- **AR backpressure.** arready=0 for 5 cycles -> araddr/arid stable, req_ready=00. On arready=1 -> handshake, and the slot reloads in the same cycle.
- **Error and unmapped ID.**
  - rresp=2'b10, rid=1 -> rsp_valid=10, rsp_err=1.
  - rid=5 -> rready=1, rsp_valid=00, unmapped_rid=1 the next cycle, outstanding decremented.
- **Reset mid-traffic.** Assert areset with 3 reads outstanding and arvalid=1 -> arvalid=0 and busy=0 immediately. After release, the first grant goes to requester 0.
